// File: rtl/matrix_port_arbiter_pkg.sv
// Shared types for the matrix port arbiter: FSM states, owner id and
// outstanding-read counter width.
package matrix_port_arbiter_pkg;

  localparam int unsigned CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef logic [1:0]           owner_t;
  typedef logic [CNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/matrix_port_arbiter.sv
// Two-requester arbiter for the shared matrix row-read / element-write port.
// Define MATRIX_ARB_ROUND_ROBIN_EN for round-robin on contention (default: requester 0 priority).
module matrix_port_arbiter
  import matrix_port_arbiter_pkg::*;
#(
  parameter  int NUM_ROWS       = 169,
  parameter  int WIDTH          = 32,
  localparam int ROW_ADDR_WIDTH = $clog2(NUM_ROWS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0,
  input  logic                      req1,
  output logic                      gnt0,
  output logic                      gnt1,
  input  logic [ROW_ADDR_WIDTH-1:0] rd0_row_addr,
  input  logic                      rd0_row_addr_ready,
  output logic                      rd0_row_valid,
  input  logic [ROW_ADDR_WIDTH-1:0] rd1_row_addr,
  input  logic                      rd1_row_addr_ready,
  output logic                      rd1_row_valid,
  input  logic [ROW_ADDR_WIDTH-1:0] wr0_row_addr,
  input  logic [ROW_ADDR_WIDTH-1:0] wr0_col_addr,
  input  logic [WIDTH-1:0]          wr0_data,
  input  logic                      wr0_ready,
  input  logic [ROW_ADDR_WIDTH-1:0] wr1_row_addr,
  input  logic [ROW_ADDR_WIDTH-1:0] wr1_col_addr,
  input  logic [WIDTH-1:0]          wr1_data,
  input  logic                      wr1_ready,
  output logic [ROW_ADDR_WIDTH-1:0] m_row_addr,
  output logic                      m_row_addr_ready,
  output logic [ROW_ADDR_WIDTH-1:0] m_write_row_addr,
  output logic [ROW_ADDR_WIDTH-1:0] m_write_col_addr,
  output logic [WIDTH-1:0]          m_write_data,
  output logic                      m_write_ready,
  input  logic                      m_row_valid,
  output logic                      busy,
  output logic                      err
);

  state_t state, state_next;
  owner_t owner, owner_next;
  count_t count, count_next;
  logic   err_next;
  logic   own_active;
  logic   sel1;
  logic   win1;
  logic   valid_ok;
  logic   stray;
  logic   sat_err;

  assign own_active = (state == OWN0) || (state == OWN1);
  assign sel1       = (owner == 2'd1);
  assign gnt0       = (state == OWN0);
  assign gnt1       = (state == OWN1);
  assign busy       = (state != IDLE);

`ifdef MATRIX_ARB_ROUND_ROBIN_EN
  logic last1;

  // last1 resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last1 <= 1'b1;
    end else if (state == IDLE && (req0 || req1)) begin
      last1 <= win1;
    end
  end

  assign win1 = req1 && (!req0 || !last1);
`else
  assign win1 = req1 && !req0;
`endif

  always_comb begin
    m_row_addr       = sel1 ? rd1_row_addr : rd0_row_addr;
    m_write_row_addr = sel1 ? wr1_row_addr : wr0_row_addr;
    m_write_col_addr = sel1 ? wr1_col_addr : wr0_col_addr;
    m_write_data     = sel1 ? wr1_data     : wr0_data;
    m_row_addr_ready = own_active && (sel1 ? rd1_row_addr_ready : rd0_row_addr_ready);
    m_write_ready    = own_active && (sel1 ? wr1_ready : wr0_ready);
  end

  // Returns with nothing outstanding are dropped rather than routed.
  assign valid_ok      = m_row_valid && (count != '0);
  assign rd0_row_valid = valid_ok && !sel1;
  assign rd1_row_valid = valid_ok && sel1;

  assign stray = ((rd0_row_addr_ready || wr0_ready) && !gnt0) ||
                 ((rd1_row_addr_ready || wr1_ready) && !gnt1);

  always_comb begin
    count_next = count;
    sat_err    = 1'b0;
    if (m_row_addr_ready && !valid_ok) begin
      if (count == '1) begin
        sat_err = 1'b1;
      end else begin
        count_next = count + count_t'(1);
      end
    end else if (!m_row_addr_ready && valid_ok) begin
      count_next = count - count_t'(1);
    end
    err_next = err || stray || sat_err || (m_row_valid && (count == '0));
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_next = win1 ? OWN1 : OWN0;
          owner_next = win1 ? 2'd1 : 2'd0;
        end
      end
      OWN0:    if (!req0) state_next = DRAIN;
      OWN1:    if (!req1) state_next = DRAIN;
      DRAIN:   if (count_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      count <= count_next;
      err   <= err_next;
    end
  end

endmodule
